// File: rtl/ifft_pkg.sv
// Shared types for the 32-point IFFT datapath.
//   IFFT_W       : width of each real/imag component (signed two's complement)
//   ifft_word_t  : one signed component
//   ifft_cplx_t  : packed complex sample {re, im}
// Later butterfly and twiddle stages reuse these so widths stay consistent.
package ifft_pkg;

  localparam int IFFT_W = 36;

  typedef logic signed [IFFT_W-1:0] ifft_word_t;

  typedef struct packed {
    ifft_word_t re;
    ifft_word_t im;
  } ifft_cplx_t;

  // Convenience constructor for a complex sample.
  function automatic ifft_cplx_t ifft_cplx(input ifft_word_t re, input ifft_word_t im);
    ifft_cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

endpackage

// File: rtl/ifft_addsub.sv
// Combinational signed add or subtract of one butterfly component.
//   a, b : WIDTH-bit signed operands
//   y    : WIDTH-bit result
// Parameters:
//   SUB   : 0 -> y = a + b, 1 -> y = a - b
//   SCALE : 1 -> arithmetic shift right by 1 (truncation toward -inf)
//   SAT   : 1 -> clamp on overflow, 0 -> wrap (ignored when SCALE=1)
// The sum is formed one bit wider than the operands so the scaled result
// and the overflow check both see the true value.
module ifft_addsub
  import ifft_pkg::*;
#(
  parameter int WIDTH = IFFT_W,
  parameter int SCALE = 0,
  parameter int SAT   = 0,
  parameter int SUB   = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] full;

  always_comb begin
    ext_a = {a[WIDTH-1], a};
    ext_b = {b[WIDTH-1], b};
    full  = (SUB != 0) ? (ext_a - ext_b) : (ext_a + ext_b);
    y     = full[WIDTH-1:0];
    if (SCALE != 0) begin
      // Dropping the LSB of the wide result halves it and can never overflow.
      y = full[WIDTH:1];
    end else if ((SAT != 0) && (full[WIDTH] != full[WIDTH-1])) begin
      // Top two bits disagree: the true value left the WIDTH-bit range.
      // full[WIDTH] is the real sign, so it picks the rail.
      y = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ifft2.sv
// Registered radix-2 complex butterfly: y1 = x1 + x2, y2 = x1 - x2.
// Twiddle multiplication happens upstream; this stage only adds/subtracts.
// Ports (positional order fixed):
//   rst              : synchronous active-high reset, clears all outputs
//   clk              : rising-edge clock
//   di1r, di1i       : x1 real / imaginary (signed WIDTH)
//   di2r, di2i       : x2 real / imaginary (signed WIDTH)
//   do1r, do1i       : y1 real / imaginary, registered
//   do2r, do2i       : y2 real / imaginary, registered
// Flow control: none. There is no valid/ready handshake; a new sample pair
// is accepted on every rising edge and its result is visible one edge later
// and held for exactly one cycle. Reset wins over data capture.
module ifft2
  import ifft_pkg::*;
#(
  parameter int WIDTH = IFFT_W,
  parameter int SCALE = 0,
  parameter int SAT   = 0
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [WIDTH-1:0] di1r,
  input  logic [WIDTH-1:0] di1i,
  input  logic [WIDTH-1:0] di2r,
  input  logic [WIDTH-1:0] di2i,
  output logic [WIDTH-1:0] do1r,
  output logic [WIDTH-1:0] do1i,
  output logic [WIDTH-1:0] do2r,
  output logic [WIDTH-1:0] do2i
);

  logic [WIDTH-1:0] do1r_d, do1i_d, do2r_d, do2i_d;
  logic [WIDTH-1:0] do1r_q, do1i_q, do2r_q, do2i_q;

  // Real and imaginary paths are independent; no cross terms.
  ifft_addsub #(.WIDTH(WIDTH), .SCALE(SCALE), .SAT(SAT), .SUB(0)) u_add_re (
    .a(di1r), .b(di2r), .y(do1r_d)
  );

  ifft_addsub #(.WIDTH(WIDTH), .SCALE(SCALE), .SAT(SAT), .SUB(0)) u_add_im (
    .a(di1i), .b(di2i), .y(do1i_d)
  );

  ifft_addsub #(.WIDTH(WIDTH), .SCALE(SCALE), .SAT(SAT), .SUB(1)) u_sub_re (
    .a(di1r), .b(di2r), .y(do2r_d)
  );

  ifft_addsub #(.WIDTH(WIDTH), .SCALE(SCALE), .SAT(SAT), .SUB(1)) u_sub_im (
    .a(di1i), .b(di2i), .y(do2i_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      do1r_q <= '0;
      do1i_q <= '0;
      do2r_q <= '0;
      do2i_q <= '0;
    end else begin
      do1r_q <= do1r_d;
      do1i_q <= do1i_d;
      do2r_q <= do2r_d;
      do2i_q <= do2i_d;
    end
  end

  assign do1r = do1r_q;
  assign do1i = do1i_q;
  assign do2r = do2r_q;
  assign do2i = do2i_q;

endmodule

// File: tb/tb_ifft2.sv
// Directed bench for ifft2. Three instances share the same inputs:
// default (wrap), SAT=1 (clamp) and SCALE=1 (halve). Inputs change on the
// falling edge; outputs are sampled on the next falling edge.
module tb_ifft2;

  localparam int W = 36;
  localparam longint MAXV = 64'sh7FFFFFFFF;
  localparam longint MINV = -64'sh800000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  logic [W-1:0] di1r, di1i, di2r, di2i;
  logic [W-1:0] w1r, w1i, w2r, w2i;   // default instance
  logic [W-1:0] s1r, s1i, s2r, s2i;   // SAT=1 instance
  logic [W-1:0] h1r, h1i, h2r, h2i;   // SCALE=1 instance

  ifft2 #(.WIDTH(W), .SCALE(0), .SAT(0)) u_dut (
    .rst(rst), .clk(clk),
    .di1r(di1r), .di1i(di1i), .di2r(di2r), .di2i(di2i),
    .do1r(w1r), .do1i(w1i), .do2r(w2r), .do2i(w2i)
  );

  ifft2 #(.WIDTH(W), .SCALE(0), .SAT(1)) u_sat (
    .rst(rst), .clk(clk),
    .di1r(di1r), .di1i(di1i), .di2r(di2r), .di2i(di2i),
    .do1r(s1r), .do1i(s1i), .do2r(s2r), .do2i(s2i)
  );

  ifft2 #(.WIDTH(W), .SCALE(1), .SAT(0)) u_scl (
    .rst(rst), .clk(clk),
    .di1r(di1r), .di1i(di1i), .di2r(di2r), .di2i(di2i),
    .do1r(h1r), .do1i(h1i), .do2r(h2r), .do2i(h2i)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference arithmetic on 64-bit integers, then cut to W bits.
  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit sub, input bit scale, input bit sat);
    longint sa, sb, r;
    logic [63:0] ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? (sa - sb) : (sa + sb);
    if (scale) r = r >>> 1;
    else if (sat) begin
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
    end
    ru = r;
    return ru[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    int unsigned sel;
    sel = $urandom_range(0, 7);
    v[31:0]  = $urandom();
    v[35:32] = 4'($urandom_range(0, 15));
    case (sel)
      0: v = 36'h7FFFFFFFF;
      1: v = 36'h800000000;
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [W-1:0] a1r, input logic [W-1:0] a1i,
                       input logic [W-1:0] a2r, input logic [W-1:0] a2i);
    rst  = r;
    di1r = a1r;
    di1i = a1i;
    di2r = a2r;
    di2i = a2i;
  endtask

  logic [W-1:0] obs[12];
  logic [W-1:0] e;

  initial begin
    // 1. reset with random inputs
    drive(1'b1, rnd_word(), rnd_word(), rnd_word(), rnd_word());
    @(negedge clk);
    check("rst_do1r", w1r, '0);
    check("rst_do1i", w1i, '0);
    check("rst_do2r", w2r, '0);
    check("rst_do2i", w2i, '0);
    check("rst_sat_do1r", s1r, '0);
    check("rst_scl_do2i", h2i, '0);

    // 2. simple add
    drive(1'b0, 36'h10000000, 36'h0, 36'h10000000, 36'h0);
    @(negedge clk);
    check("t2_do1r", w1r, 36'h20000000);
    check("t2_do1i", w1i, 36'h0);
    check("t2_do2r", w2r, 36'h0);
    check("t2_do2i", w2i, 36'h0);

    // 3. mixed real/imag
    drive(1'b0, 36'h20000000, 36'h10000000, 36'h10000000, 36'h10000000);
    @(negedge clk);
    check("t3_do1r", w1r, 36'h30000000);
    check("t3_do1i", w1i, 36'h20000000);
    check("t3_do2r", w2r, 36'h10000000);
    check("t3_do2i", w2i, 36'h0);
    check("t3_scl_do1r", h1r, 36'h18000000);

    // 4. negative operands: -5 and 3
    drive(1'b0, 36'hFFFFFFFFB, 36'h0, 36'h3, 36'h0);
    @(negedge clk);
    check("t4_do1r", w1r, 36'hFFFFFFFFE);
    check("t4_do2r", w2r, 36'hFFFFFFFF8);
    check("t4_scl_do1r", h1r, 36'hFFFFFFFFF);  // -2 >> 1 = -1
    check("t4_scl_do2r", h2r, 36'hFFFFFFFFC);  // -8 >> 1 = -4

    // 5. positive overflow
    drive(1'b0, 36'h7FFFFFFFF, 36'h0, 36'h7FFFFFFFF, 36'h0);
    @(negedge clk);
    check("t5_wrap_do1r", w1r, 36'hFFFFFFFFE);
    check("t5_sat_do1r", s1r, 36'h7FFFFFFFF);
    check("t5_scl_do1r", h1r, 36'h7FFFFFFFF);
    check("t5_wrap_do2r", w2r, 36'h0);

    // 5b. negative overflow on add, positive overflow on subtract (imag path)
    drive(1'b0, 36'h800000000, 36'h7FFFFFFFF, 36'h800000000, 36'h800000000);
    @(negedge clk);
    check("t5b_wrap_do1r", w1r, 36'h000000000);
    check("t5b_sat_do1r", s1r, 36'h800000000);
    check("t5b_scl_do1r", h1r, 36'h800000000);
    check("t5b_wrap_do2i", w2i, 36'hFFFFFFFFF);
    check("t5b_sat_do2i", s2i, 36'h7FFFFFFFF);
    check("t5b_scl_do2i", h2i, 36'h7FFFFFFFF);
    check("t5b_sat_do1i", s1i, 36'hFFFFFFFFF);

    // 6. streaming with a reset in the middle
    for (int c = 0; c < 32; c++) begin
      logic [W-1:0] a1r, a1i, a2r, a2i;
      logic r;
      a1r = rnd_word();
      a1i = rnd_word();
      a2r = rnd_word();
      a2i = rnd_word();
      r   = (c == 16);
      drive(r, a1r, a1i, a2r, a2i);
      for (int k = 0; k < 3; k++) begin
        bit scl, sat;
        scl = (k == 2);
        sat = (k == 1);
        exp_q.push_back(r ? '0 : golden(a1r, a2r, 1'b0, scl, sat));
        exp_q.push_back(r ? '0 : golden(a1i, a2i, 1'b0, scl, sat));
        exp_q.push_back(r ? '0 : golden(a1r, a2r, 1'b1, scl, sat));
        exp_q.push_back(r ? '0 : golden(a1i, a2i, 1'b1, scl, sat));
      end
      @(negedge clk);
      obs = '{w1r, w1i, w2r, w2i, s1r, s1i, s2r, s2i, h1r, h1i, h2r, h2i};
      for (int k = 0; k < 12; k++) begin
        e = exp_q.pop_front();
        check($sformatf("stream_c%0d_o%0d", c, k), obs[k], e);
      end
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
